// File: rtl/sha1_search_ctrl_pkg.sv
// Shared constants, types and helpers for the SHA-1 nonce search sequencer.
package sha1_search_ctrl_pkg;

    localparam int SHA1_PIPE_LATENCY = 82;

    localparam int WORD_W = 32;
    localparam int MSG_W  = 512;
    localparam int HASH_W = 160;

    // SHA-1 initial hash value.
    localparam logic [WORD_W-1:0] SHA1_H0 = 32'h6745_2301;
    localparam logic [WORD_W-1:0] SHA1_H1 = 32'hEFCD_AB89;
    localparam logic [WORD_W-1:0] SHA1_H2 = 32'h98BA_DCFE;
    localparam logic [WORD_W-1:0] SHA1_H3 = 32'h1032_5476;
    localparam logic [WORD_W-1:0] SHA1_H4 = 32'hC3D2_E1F0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Replace one 32-bit word of a message block. Word 0 is the most
    // significant word (bits 511:480), matching SHA-1 schedule word W[0].
    function automatic logic [MSG_W-1:0] insert_word(input logic [MSG_W-1:0] base,
                                                     input int               idx,
                                                     input logic [WORD_W-1:0] word);
        logic [MSG_W-1:0] m;
        m = base;
        m[MSG_W-1-WORD_W*idx -: WORD_W] = word;
        return m;
    endfunction

endpackage

// File: rtl/sha1_search_ctrl_tag.sv
// Fixed-depth shift line of {valid, data} tags that travels alongside the
// SHA-1 pipeline. Only the valid bits are reset so stale work is forgotten.
module sha1_tag_delay #(
    parameter int DEPTH = 82,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         tail_valid_o,
    output logic [W-1:0] tail_data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Valid bits shift every cycle; reset clears all in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], push_valid_i};
        end
    end

    // Payload shifts every cycle; it is meaningless while its valid bit is low.
    always_ff @(posedge clk) begin
        data_q[0] <= push_data_i;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign tail_valid_o = valid_q[DEPTH-1];
    assign tail_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sha1_search_ctrl.sv
// Nonce search sequencer for an unrolled SHA-1 pipeline: issues one candidate
// message per cycle, follows each nonce through the pipeline with a tag, and
// reports masked-target hits on a single-entry valid/ready match port.
// Match port: match_valid/match_nonce are held stable until a cycle in which
// match_valid && match_ready, which completes the transfer.
module sha1_search_ctrl
    import sha1_search_ctrl_pkg::*;
#(
    parameter int PIPE_LATENCY = SHA1_PIPE_LATENCY,
    parameter int NONCE_WORD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MSG_W-1:0]  cfg_base,
    input  logic [HASH_W-1:0] cfg_target,
    input  logic [HASH_W-1:0] cfg_mask,
    input  logic [WORD_W-1:0] cfg_nonce_first,
    input  logic [WORD_W-1:0] cfg_nonce_last,
    output logic [MSG_W-1:0]  msg_data,
    input  logic [HASH_W-1:0] sha_hash,
    output logic              match_valid,
    input  logic              match_ready,
    output logic [WORD_W-1:0] match_nonce,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              overflow
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

    state_t            state_q, state_d;
    logic [MSG_W-1:0]  base_q;
    logic [HASH_W-1:0] target_q, mask_q;
    logic [WORD_W-1:0] last_q;
    logic [WORD_W:0]   nonce_q;          // 33 bits so the last nonce FFFFFFFF cannot wrap
    logic [MSG_W-1:0]  msg_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              abort_seen_q, aborted_q, overflow_q;
    logic              match_valid_q;
    logic [WORD_W-1:0] match_nonce_q;

    logic              start_acc, abort_acc, issue;
    logic              tail_valid, hit;
    logic [WORD_W-1:0] tail_nonce;

    sha1_tag_delay #(
        .DEPTH (PIPE_LATENCY),
        .W     (WORD_W)
    ) u_tag (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (issue),
        .push_data_i  (nonce_q[WORD_W-1:0]),
        .tail_valid_o (tail_valid),
        .tail_data_o  (tail_nonce)
    );

    assign hit     = tail_valid && (((sha_hash ^ target_q) & mask_q) == '0);
    assign count_d = count_q + CNT_W'(issue) - CNT_W'(tail_valid);

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        abort_acc = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (cfg_nonce_last < cfg_nonce_first) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    abort_acc = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (nonce_q == {1'b0, last_q}) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final tag pops this cycle.
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Search configuration, captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            base_q   <= cfg_base;
            target_q <= cfg_target;
            mask_q   <= cfg_mask;
            last_q   <= cfg_nonce_last;
        end
    end

    // State, issue datapath, in-flight count, status flags and match holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            nonce_q       <= '0;
            msg_q         <= '0;
            count_q       <= '0;
            abort_seen_q  <= 1'b0;
            aborted_q     <= 1'b0;
            overflow_q    <= 1'b0;
            match_valid_q <= 1'b0;
            match_nonce_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (start_acc) begin
                nonce_q      <= {1'b0, cfg_nonce_first};
                abort_seen_q <= 1'b0;
                aborted_q    <= 1'b0;
                overflow_q   <= 1'b0;
            end
            if (issue) begin
                msg_q   <= insert_word(base_q, NONCE_WORD, nonce_q[WORD_W-1:0]);
                nonce_q <= nonce_q + 1'b1;
            end
            if (abort_acc) abort_seen_q <= 1'b1;
            if (state_q == DONE && abort_seen_q) aborted_q <= 1'b1;
            if (hit) begin
                if (!match_valid_q || match_ready) begin
                    match_valid_q <= 1'b1;
                    match_nonce_q <= tail_nonce;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (match_valid_q && match_ready) begin
                match_valid_q <= 1'b0;
            end
        end
    end

    assign msg_data    = msg_q;
    assign match_valid = match_valid_q;
    assign match_nonce = match_nonce_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign aborted     = aborted_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sha1_search_ctrl.sv
// Directed bench for sha1_search_ctrl with a behavioural SHA-1 pipeline model.
module tb_sha1_search_ctrl;

    localparam int LAT = 82;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [511:0] cfg_base = '0;
    logic [159:0] cfg_target = '0;
    logic [159:0] cfg_mask = '0;
    logic [31:0]  cfg_nonce_first = '0;
    logic [31:0]  cfg_nonce_last = '0;
    logic [511:0] msg_data;
    logic [159:0] sha_hash;
    logic         match_valid;
    logic         match_ready = 1'b0;
    logic [31:0]  match_nonce;
    logic         busy, done, aborted, overflow;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] got_q[$];
    int          got_cyc_q[$];
    logic [31:0] exp_q[$];

    sha1_search_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_base        (cfg_base),
        .cfg_target      (cfg_target),
        .cfg_mask        (cfg_mask),
        .cfg_nonce_first (cfg_nonce_first),
        .cfg_nonce_last  (cfg_nonce_last),
        .msg_data        (msg_data),
        .sha_hash        (sha_hash),
        .match_valid     (match_valid),
        .match_ready     (match_ready),
        .match_nonce     (match_nonce),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .overflow        (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference SHA-1 (single block, IV added) ----------------
    function automatic logic [159:0] sha1_blk(input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
        d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
                d + 32'h10325476, e + 32'hC3D2E1F0};
    endfunction

    function automatic logic [511:0] ins_word0(input logic [511:0] base, input logic [31:0] n);
        logic [511:0] m;
        m = base;
        m[511:480] = n;
        return m;
    endfunction

    function automatic logic [511:0] make_base(input logic [31:0] seed);
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = seed ^ (32'h61626300 + i);
        return m;
    endfunction

    // Pipeline model: a message registered at the end of cycle t (visible on
    // msg_data from t+1) has its hash on sha_hash during cycle t+LAT.
    logic [159:0] hp [LAT-1];
    always @(posedge clk) begin
        hp[0] <= sha1_blk(msg_data);
        for (int i = 1; i < LAT-1; i++) hp[i] <= hp[i-1];
    end
    assign sha_hash = hp[LAT-2];

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset && match_valid && match_ready) begin
            got_q.push_back(match_nonce);
            got_cyc_q.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic check_matches(input string tag);
        check({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_nonce%0d", tag, i), 512'(got_q[i]), 512'(exp_q[i]));
    endtask

    // ---------------- drivers ----------------
    task automatic do_start(input logic [511:0] base, input logic [159:0] target,
                            input logic [159:0] mask, input logic [31:0] first,
                            input logic [31:0] last);
        @(posedge clk); #1;
        cfg_base = base; cfg_target = target; cfg_mask = mask;
        cfg_nonce_first = first; cfg_nonce_last = last;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns k = number of cycles after the start edge at which done is seen.
    task automatic wait_done(input string tag, input int bound, output int k);
        k = 0;
        while (k < bound) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        check({tag, "_done_seen"}, 512'(done), 512'(1));
    endtask

    task automatic pulse_ready;
        @(posedge clk); #1; match_ready = 1'b1;
        @(posedge clk); #1; match_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] base;
        logic [511:0] last_msg;
        int k, d0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_msg", msg_data, 512'(0));
        check("rst_mvalid", 512'(match_valid), 512'(0));
        check("rst_mnonce", 512'(match_nonce), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_aborted", 512'(aborted), 512'(0));
        check("rst_overflow", 512'(overflow), 512'(0));
        @(posedge clk); #1; reset = 1'b0;

        // 1: exact target for nonce 5, full mask, hold the match.
        base = make_base(32'h1111_0000);
        do_start(base, sha1_blk(ins_word0(base, 32'd5)), {160{1'b1}}, 32'd0, 32'd9);
        wait_done("t1", 300, k);
        check("t1_latency", 512'(k), 512'(93));
        check("t1_busy_at_done", 512'(busy), 512'(0));
        repeat (2) @(negedge clk);
        check("t1_mvalid", 512'(match_valid), 512'(1));
        check("t1_mnonce", 512'(match_nonce), 512'(5));
        check("t1_overflow", 512'(overflow), 512'(0));
        check("t1_aborted", 512'(aborted), 512'(0));
        check("t1_msg_hold", msg_data, ins_word0(base, 32'd9));
        pulse_ready();
        @(negedge clk);
        check("t1_mvalid_cleared", 512'(match_valid), 512'(0));

        // 2: mask 0, ready held high, consecutive hits.
        got_q.delete(); got_cyc_q.delete();
        match_ready = 1'b1;
        base = make_base(32'h2222_0000);
        do_start(base, '0, '0, 32'd100, 32'd102);
        wait_done("t2", 300, k);
        check("t2_latency", 512'(k), 512'(86));
        repeat (3) @(negedge clk);
        exp_q = '{32'd100, 32'd101, 32'd102};
        check_matches("t2");
        if (got_cyc_q.size() == 3) begin
            check("t2_gap01", 512'(got_cyc_q[1] - got_cyc_q[0]), 512'(1));
            check("t2_gap12", 512'(got_cyc_q[2] - got_cyc_q[1]), 512'(1));
        end
        check("t2_overflow", 512'(overflow), 512'(0));
        match_ready = 1'b0;

        // 3: mask 0, ready held low, overflow.
        base = make_base(32'h3333_0000);
        do_start(base, '0, '0, 32'd0, 32'd3);
        wait_done("t3", 300, k);
        repeat (2) @(negedge clk);
        check("t3_mvalid", 512'(match_valid), 512'(1));
        check("t3_mnonce", 512'(match_nonce), 512'(0));
        check("t3_overflow", 512'(overflow), 512'(1));
        pulse_ready();
        @(negedge clk);
        check("t3_mvalid_cleared", 512'(match_valid), 512'(0));

        // 4: top of nonce space, no wrap.
        got_q.delete();
        match_ready = 1'b1;
        d0 = done_cnt;
        base = make_base(32'h4444_0000);
        do_start(base, '0, '0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_done("t4", 300, k);
        check("t4_latency", 512'(k), 512'(85));
        check("t4_overflow_cleared", 512'(overflow), 512'(0));
        repeat (100) @(negedge clk);
        exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
        check_matches("t4");
        check("t4_done_once", 512'(done_cnt - d0), 512'(1));
        check("t4_msg_last", msg_data, ins_word0(base, 32'hFFFF_FFFF));

        // 4b: empty range first > last.
        last_msg = msg_data;
        got_q.delete();
        do_start(make_base(32'h5555_0000), '0, '0, 32'd5, 32'd4);
        wait_done("t4b", 10, k);
        check("t4b_latency", 512'(k), 512'(1));
        repeat (100) @(negedge clk);
        check("t4b_no_issue", msg_data, last_msg);
        check("t4b_no_match", 512'(got_q.size()), 512'(0));

        // 5: abort ten cycles into a long range.
        got_q.delete();
        do_start(make_base(32'h6666_0000), '0, '0, 32'd0, 32'd1000);
        repeat (9) @(posedge clk);
        #1;
        check("t5_busy", 512'(busy), 512'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("t5", 300, k);
        check("t5_latency", 512'(k), 512'(82));
        repeat (3) @(negedge clk);
        check("t5_aborted", 512'(aborted), 512'(1));
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i));
        check_matches("t5");

        // 6: reset in the middle of a run, then a single-nonce search.
        do_start(make_base(32'h7777_0000), '0, '0, 32'd0, 32'd1000);
        repeat (20) @(posedge clk);
        #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_rst_busy", 512'(busy), 512'(0));
        check("t6_rst_msg", msg_data, 512'(0));
        check("t6_rst_aborted", 512'(aborted), 512'(0));
        @(posedge clk); #1; reset = 1'b0;
        got_q.delete();
        do_start(make_base(32'h8888_0000), '0, '0, 32'd50, 32'd50);
        wait_done("t6", 300, k);
        check("t6_latency", 512'(k), 512'(84));
        repeat (100) @(negedge clk);
        exp_q = '{32'd50};
        check_matches("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha1_search_ctrl.md
Name: sha1_search_ctrl

Overview:
Sequencer for the fully unrolled 82-cycle SHA-1 pipeline, which issues one message per cycle.
- Builds candidate messages from a base message with a 32-bit nonce inserted into one word, and issues one per cycle over a programmed nonce range.
- Tracks each in-flight nonce alongside the pipeline and compares every emerging hash against a masked target.
- Reports hits through a valid/ready match port.
- Sits between the host/config logic and the sha1 pipeline instance.

Parameters:
PIPE_LATENCY, 82, cycles from msg_data driven (cycle t) to its hash visible on sha_hash (cycle t+PIPE_LATENCY).
NONCE_WORD, 0, 32-bit word index (0..15) of the 512-bit message replaced by the nonce.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; accepted only in IDLE; latches all cfg_* inputs
abort  in  1  pulse; stops issuing and begins drain
cfg_base  in  512  base expanded message
cfg_target  in  160  target hash
cfg_mask  in  160  compare mask; 1 = bit compared
cfg_nonce_first  in  32  first nonce, inclusive
cfg_nonce_last  in  32  last nonce, inclusive
msg_data  out  512  to sha1 rx_data; registered
sha_hash  in  160  from sha1 tx_hash
match_valid  out  1  hit available
match_ready  in  1  consumer accepts the hit
match_nonce  out  32  nonce of the hit
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at end of search
aborted  out  1  sticky; search ended by abort; cleared on start
overflow  out  1  sticky; a hit was dropped; cleared on start

Behaviour:
- Reset clears: state=IDLE, msg_data=0, match_valid=0, match_nonce=0, busy=0, done=0, aborted=0, overflow=0, all tag valid bits=0, in-flight count=0.
- Reset mid-search discards in-flight work; hashes still in the pipeline after reset are never reported.
- States:
  - IDLE: on start, latch config, nonce=cfg_nonce_first, go to RUN. If cfg_nonce_last < cfg_nonce_first, go directly to DONE (nothing issued).
  - RUN: each cycle drive msg_data = cfg_base with word NONCE_WORD = nonce (registered), push {1, nonce} into the tag delay line, increment nonce. After issuing cfg_nonce_last, go to DRAIN. Use a 33-bit compare so cfg_nonce_last=FFFFFFFF terminates with no wrap.
  - abort in RUN: no issue that cycle; go to DRAIN. abort in IDLE, DRAIN or DONE is ignored.
  - DRAIN: push invalid tags; stay while the in-flight count is nonzero; then go to DONE.
  - DONE: done=1 for one cycle; set aborted if the search was aborted; go to IDLE.
  - start is ignored outside IDLE.
- Tag delay line:
  - PIPE_LATENCY stages of {valid, nonce}, aligned so stage PIPE_LATENCY-1 corresponds to sha_hash in the same cycle.
  - The in-flight counter increments on a valid push, decrements on a valid pop, and is unchanged when both occur in the same cycle.
- Compare: hit = tail valid AND ((sha_hash ^ cfg_target) & cfg_mask) == 0. A hit with mask=0 always matches.
- Match port:
  - Single holding register.
  - On a hit while !match_valid, or while match_valid && match_ready: load nonce, set match_valid=1.
  - On a hit while match_valid && !match_ready: drop the hit, set overflow=1, keep the held nonce.
  - match_valid/match_nonce hold stable until the handshake completes.
  - A match held at DONE persists across IDLE until consumed, and is cleared only by reset.
- The pipeline is never stalled; msg_data keeps its last value when not issuing.
- busy = (state==RUN || state==DRAIN).
- Total cycles from start to done for N nonces: N + PIPE_LATENCY + 1.

Decomposition:
- Shared package:
  - SHA1_PIPE_LATENCY=82
  - SHA-1 IV constants
  - WORD_W=32, MSG_W=512, HASH_W=160
  - state enum {IDLE, RUN, DRAIN, DONE}
- Sub-module sha1_tag_delay (parameterised depth/width shift line of {valid, nonce}, synchronous reset of valid bits only).

Test Plan:
- Range 0..9, target = SHA-1 of base with nonce 5 in word 0, mask all-ones -> exactly one match, match_nonce=5; done 93 cycles after start (10+82+1); aborted=0; overflow=0.
- Mask=0, range 100..102, match_ready held 1 -> matches 100, 101, 102 on consecutive cycles; overflow=0.
- Mask=0, range 0..3, match_ready held 0 -> match_nonce stays 0, overflow=1; after ready pulses, match_valid drops.
- Range FFFFFFFE..FFFFFFFF -> exactly 2 issues, no wrap to 0, done once; first>last (5..4) -> done 1 cycle after start, no issue.
- abort 10 cycles into range 0..1000 -> issues stop; done after in-flight count reaches 0; aborted=1; no nonce >= 10 reported.
- reset asserted mid-RUN, then new start with mask=0, range 50..50 -> only nonce 50 reported; no stale hits.
